// File: rtl/ram_pkg.sv
// ram_pkg: shared state encoding and default geometry for the RAM loader
package ram_pkg;
  typedef enum logic [2:0] {IDLE, WRITE, VERIFY_ADDR, VERIFY_CMP, DONE} state_t;
  localparam int N_DEF          = 4;
  localparam int DEPTH_DEF      = 16;
  localparam int DATA_WIDTH_DEF = 8;
endpackage

// File: rtl/ram_checksum.sv
// ram_checksum: clearable running sum of accepted words
module ram_checksum
  import ram_pkg::*;
#(
  parameter int DW = DATA_WIDTH_DEF,
  parameter int SW = DATA_WIDTH_DEF + N_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [SW-1:0] sum
);
  logic [SW-1:0] sum_q, sum_d;
  // clear wins over accumulate so a new load always starts from zero
  always_comb sum_d = clear ? '0 : (en ? sum_q + SW'(din) : sum_q);
  // sum register
  always_ff @(posedge clk)
    if (rst) sum_q <= '0;
    else sum_q <= sum_d;
  assign sum = sum_q;
endmodule

// File: rtl/ram_loader.sv
// ram_loader: streams DEPTH words into a RAM, optional readback checksum verify (RAM_VERIFY_EN)
module ram_loader
  import ram_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  ram_we,
  output logic [N-1:0]          ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  localparam int SW = DATA_WIDTH + N;
  localparam logic [N-1:0] LAST = N'(DEPTH - 1);
  state_t state_q, state_d;
  logic [N-1:0] wr_cnt_q, wr_cnt_d;
  logic [SW-1:0] wr_sum;
  logic clr, wr_en;
  assign wr_en = (state_q == WRITE) && s_valid;
  ram_checksum #(.DW(DATA_WIDTH), .SW(SW)) u_wr_sum (
    .clk(clk), .rst(rst), .clear(clr), .en(wr_en), .din(s_data), .sum(wr_sum)
  );
`ifdef RAM_VERIFY_EN
  logic [N-1:0] rd_cnt_q, rd_cnt_d;
  logic [SW-1:0] rd_sum;
  logic error_q, error_d, rd_en, verifying;
  assign rd_en     = state_q == VERIFY_CMP;
  assign verifying = (state_q == VERIFY_ADDR) || (state_q == VERIFY_CMP);
  ram_checksum #(.DW(DATA_WIDTH), .SW(SW)) u_rd_sum (
    .clk(clk), .rst(rst), .clear(clr), .en(rd_en), .din(ram_dout), .sum(rd_sum)
  );
`else
  logic unused_verify;
  assign unused_verify = ^{ram_dout, wr_sum};
`endif
  // next-state, counters and verify result
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    clr      = 1'b0;
`ifdef RAM_VERIFY_EN
    rd_cnt_d = rd_cnt_q;
    error_d  = error_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        clr      = 1'b1;
        wr_cnt_d = '0;
        state_d  = WRITE;
`ifdef RAM_VERIFY_EN
        rd_cnt_d = '0;
        error_d  = 1'b0;
`endif
      end
      WRITE: if (s_valid) begin
        wr_cnt_d = wr_cnt_q + 1'b1;
`ifdef RAM_VERIFY_EN
        if (wr_cnt_q == LAST) state_d = VERIFY_ADDR;
`else
        if (wr_cnt_q == LAST) state_d = DONE;
`endif
      end
`ifdef RAM_VERIFY_EN
      VERIFY_ADDR: state_d = VERIFY_CMP;
      VERIFY_CMP: begin
        rd_cnt_d = rd_cnt_q + 1'b1;
        state_d  = (rd_cnt_q == LAST) ? DONE : VERIFY_ADDR;
        if (rd_cnt_q == LAST) error_d = (rd_sum + SW'(ram_dout)) != wr_sum;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and counter registers
  always_ff @(posedge clk)
    if (rst) begin
      state_q  <= IDLE;
      wr_cnt_q <= '0;
`ifdef RAM_VERIFY_EN
      rd_cnt_q <= '0;
      error_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
`ifdef RAM_VERIFY_EN
      rd_cnt_q <= rd_cnt_d;
      error_q  <= error_d;
`endif
    end
  // outputs decoded from state; rst masks the write strobe so an abort never lands a word
  always_comb begin
    s_ready = state_q == WRITE;
    ram_we  = s_ready && s_valid && !rst;
    ram_din = s_ready ? s_data : '0;
    done    = state_q == DONE;
`ifdef RAM_VERIFY_EN
    ram_addr = s_ready ? wr_cnt_q : (verifying ? rd_cnt_q : '0);
    busy     = s_ready || verifying;
    error    = error_q;
`else
    ram_addr = s_ready ? wr_cnt_q : '0;
    busy     = s_ready;
    error    = 1'b0;
`endif
  end
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: directed scoreboard bench for ram_loader with a behavioural single-port RAM (RAM_VERIFY_EN aware)
module tb_ram_loader;
`ifdef RAM_VERIFY_EN
  localparam int VLAT = 32;
  localparam bit VER = 1'b1;
`else
  localparam int VLAT = 0;
  localparam bit VER = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, start, s_valid, s_ready, ram_we, busy, done, error, bd_we;
  logic [7:0] s_data, ram_din, ram_dout, bd_data;
  logic [3:0] ram_addr;
  logic [7:0] mem [16];
  logic [7:0] snap [16];
  logic [7:0] dat [16];
  int n_cmp = 0, n_bad = 0;
  typedef struct {logic [3:0] a; logic [7:0] d;} wr_t;
  wr_t exp_q[$];
  always #5 clk = ~clk;
  ram_loader dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .busy(busy), .done(done), .error(error)
  );
  // single-port RAM with synchronous read plus a backdoor write to word 0
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    if (bd_we) mem[0] <= bd_data;
    ram_dout <= mem[ram_addr];
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // every RAM write must match the next scoreboard entry
  always @(negedge clk)
    if (ram_we === 1'b1) begin
      wr_t e;
      if (exp_q.size() == 0) check("spurious_we", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(ram_addr), 32'(e.a));
        check("wr_data", 32'(ram_din), 32'(e.d));
      end
    end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input bit toggle, input bit bd, input bit pulse, input bit rnd, input bit exp_err);
    int idx = 0, cyc_n = 0, lat = 0;
    for (int i = 0; i < 16; i++) dat[i] = rnd ? 8'($urandom) : 8'(i);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_ready", 32'(s_ready), 1);
    check("err_cleared", 32'(error), 0);
    while (idx < 16 && cyc_n < 100) begin
      s_valid = toggle ? (cyc_n[0] == 1'b0) : 1'b1;
      s_data  = s_valid ? dat[idx] : 8'hAA;
      start   = pulse && (cyc_n % 3 == 2);
      bd_we   = bd && s_valid && idx == 15;
      bd_data = 8'hFF;
      if (s_valid) exp_q.push_back('{4'(idx), dat[idx]});
      #1;
      check("we_follows_valid", 32'(ram_we), 32'(s_valid));
      cyc();
      if (s_valid) idx++;
      cyc_n++;
    end
    s_valid = 1'b0;
    bd_we = 1'b0;
    start = 1'b0;
    check("beats", idx, 16);
    check("write_cycles", cyc_n, toggle ? 31 : 16);
    while (done !== 1'b1 && lat < 200) begin
      start = pulse && (lat % 4 == 1);
      if (VER) check("verify_no_we", 32'(ram_we), 0);
      cyc();
      lat++;
    end
    start = 1'b0;
    check("done_latency", lat, VLAT);
    check("done", 32'(done), 1);
    check("error", 32'(error), 32'(exp_err));
    cyc();
    check("done_pulse", 32'(done), 0);
    check("idle_busy", 32'(busy), 0);
    check("err_held", 32'(error), 32'(exp_err));
    check("sb_empty", exp_q.size(), 0);
    for (int i = 0; i < 16; i++)
      check("ram_word", 32'(mem[i]), 32'((bd && i == 0) ? 8'hFF : dat[i]));
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; bd_we = 1'b0; bd_data = '0;
    repeat (3) cyc();
    rst = 1'b0;
    check("rst_ready", 32'(s_ready), 0);
    check("rst_we", 32'(ram_we), 0);
    check("rst_addr", 32'(ram_addr), 0);
    check("rst_din", 32'(ram_din), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    load(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    load(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    load(1'b0, 1'b1, 1'b0, 1'b0, VER);
    load(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) snap[i] = mem[i];
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data = 8'h50 + 8'(i);
      exp_q.push_back('{4'(i), 8'h50 + 8'(i)});
      cyc();
    end
    s_valid = 1'b1;
    s_data = 8'h55;
    rst = 1'b1;
    #1;
    check("rst_we_gate", 32'(ram_we), 0);
    cyc();
    rst = 1'b0;
    s_valid = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_ready", 32'(s_ready), 0);
    check("abort_we", 32'(ram_we), 0);
    check("abort_addr", 32'(ram_addr), 0);
    check("abort_done", 32'(done), 0);
    check("abort_sb", exp_q.size(), 0);
    for (int i = 0; i < 5; i++) check("abort_written", 32'(mem[i]), 32'(8'h50 + 8'(i)));
    for (int i = 6; i < 16; i++) check("abort_untouched", 32'(mem[i]), 32'(snap[i]));
    load(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    load(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter N, default 4: RAM address width.
REQ-002 Parameter DEPTH, default 16: words to load, DEPTH <= 2**N.
REQ-003 Parameter DATA_WIDTH, default 8: RAM word width.
REQ-004 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port rst  input  1  synchronous active-high reset.
REQ-006 Port start  input  1  begin a load; sampled only in IDLE.
REQ-007 Port s_valid  input  1  upstream word valid.
REQ-008 Port s_data  input  DATA_WIDTH  upstream word.
REQ-009 Port s_ready  output  1  loader accepts a word this cycle.
REQ-010 Port ram_we  output  1  RAM write enable.
REQ-011 Port ram_addr  output  N  RAM address.
REQ-012 Port ram_din  output  DATA_WIDTH  RAM write data.
REQ-013 Port ram_dout  input  DATA_WIDTH  RAM read data.
REQ-014 Port busy  output  1  high in WRITE, VERIFY_ADDR, VERIFY_CMP.
REQ-015 Port done  output  1  one-cycle completion pulse.
REQ-016 Port error  output  1  verify mismatch flag, held until next accepted start.

Function
REQ-017 States: IDLE, WRITE, VERIFY_ADDR, VERIFY_CMP, DONE.
REQ-018 IDLE with start=1 SHALL clear write count, both checksums and error, then enter WRITE; start in any other state SHALL be ignored.
REQ-019 s_ready SHALL equal (state==WRITE); a transfer occurs when s_valid && s_ready.
REQ-020 In WRITE, ram_we=s_valid, ram_addr=write count, ram_din=s_data combinationally, so the RAM captures each word on the handshake edge.
REQ-021 Write count SHALL start at 0 and increment by 1 per transfer, no gaps under s_valid stalls; wr_sum += s_data per transfer.
REQ-022 The transfer at count DEPTH-1 SHALL end WRITE: next state VERIFY_ADDR with RAM_VERIFY_EN, otherwise DONE.
REQ-023 VERIFY_ADDR: ram_we=0, ram_addr=read count; next state VERIFY_CMP.
REQ-024 VERIFY_CMP: ram_addr held; rd_sum += ram_dout; read count +1; next state VERIFY_ADDR, or DONE after address DEPTH-1 (2 cycles per word).
REQ-025 Both checksums SHALL be DATA_WIDTH+N bits wide unsigned; no overflow is possible.
REQ-026 On VERIFY_CMP->DONE, error SHALL be registered as (rd_sum_final != wr_sum).
REQ-027 DONE SHALL last exactly one cycle with done=1, then enter IDLE.
REQ-028 Outside WRITE ram_we SHALL be 0; outside WRITE and VERIFY states ram_addr and ram_din SHALL be 0.

Reset
REQ-029 rst=1 SHALL force IDLE, counters and checksums 0, error 0; outputs s_ready, ram_we, ram_addr, ram_din, busy, done all 0 in the following cycle.
REQ-030 rst mid-load SHALL abort without further RAM writes; a subsequent start SHALL restart from address 0.

Configuration
REQ-031 Macro RAM_VERIFY_EN defined: readback verify states, rd_sum and error logic compiled in.
REQ-032 Macro RAM_VERIFY_EN undefined: VERIFY states and rd_sum absent, error tied 0, WRITE goes directly to DONE.

Structure
REQ-033 Package ram_pkg SHALL hold the state encoding type and default N/DEPTH/DATA_WIDTH constants.
REQ-034 Sub-module ram_checksum (clear, enable, data in, DATA_WIDTH+N sum out) SHALL be instantiated for wr_sum and rd_sum.

Verification (N=4, DEPTH=16, DATA_WIDTH=8, loader driving single_port_ram)
REQ-035 start, s_valid held 1, data 0x00..0x0F -> writes addr 0..15 on 16 consecutive cycles, RAM matches, 32 verify cycles, done pulse, error=0.
REQ-036 s_valid toggling every other cycle -> exactly 16 writes, contiguous addresses 0..15, ram_we only on valid cycles.
REQ-037 After write phase, backdoor-force RAM addr 0 to 0xFF (data was 0x00) -> done with error=1; error clears on next start.
REQ-038 rst asserted at write address 5 -> next cycle IDLE, busy=0, ram_we=0, addr 6..15 untouched; new start rewrites from addr 0.
REQ-039 start pulsed during WRITE and VERIFY -> no effect on counters, addresses or done timing.
REQ-040 RAM_VERIFY_EN undefined -> done one cycle after 16th handshake, error=0, no read cycles.
